alu_unit: RTL and testbench

//   RV32I integer ALU in the execute stage; computes c_o from a_i/b_i per alu_op_i.

---
 rtl/alu_unit.sv | 140 ++++++++++++++
 tb/tb_alu_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/alu_unit.sv
// alu_unit: RV32I-style integer ALU for the execute stage.
//
// The result path is purely combinational, so the core can use c_o in the
// same cycle. A registered copy of the last result (c_q_o) supports
// forwarding and debug.
//
// Optional feature macro: ALU_FLAGS_EN
//   When defined, adds a registered {N,Z,C,V} flag output (flags_o).
//   When undefined, the flags port and the flag logic are absent.
//
// Ports:
//   clk_i     in   1           clock, rising edge
//   rst_ni    in   1           asynchronous active-low reset
//   alu_op_i  in   6           operation select
//   a_i       in   DATA_WIDTH  operand A (rs1 / PC)
//   b_i       in   DATA_WIDTH  operand B (rs2 / immediate)
//   c_o       out  DATA_WIDTH  combinational result
//   zero_o    out  1           combinational, high when c_o == 0
//   c_q_o     out  DATA_WIDTH  c_o captured on every rising edge
//   flags_o   out  4           registered {N,Z,C,V} (ALU_FLAGS_EN only)

module alu_unit #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [5:0]            alu_op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] c_o,
    output logic                  zero_o,
    output logic [DATA_WIDTH-1:0] c_q_o
`ifdef ALU_FLAGS_EN
    ,
    output logic [3:0]            flags_o
`endif
);

    localparam int unsigned SHIFT_W = $clog2(DATA_WIDTH);

    localparam logic [5:0] OP_ADD   = 6'd0;
    localparam logic [5:0] OP_SUB   = 6'd1;
    localparam logic [5:0] OP_AND   = 6'd2;
    localparam logic [5:0] OP_OR    = 6'd3;
    localparam logic [5:0] OP_XOR   = 6'd4;
    localparam logic [5:0] OP_SLT   = 6'd5;
    localparam logic [5:0] OP_SLTU  = 6'd6;
    localparam logic [5:0] OP_SLL   = 6'd7;
    localparam logic [5:0] OP_SRL   = 6'd8;
    localparam logic [5:0] OP_SRA   = 6'd9;
    localparam logic [5:0] OP_PASSB = 6'd10;

    logic [SHIFT_W-1:0]    shamt;
    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] diff;
    logic [DATA_WIDTH-1:0] sra_res;
    logic                  lt_signed;
    logic                  lt_unsigned;
    logic [DATA_WIDTH-1:0] c_d;
    logic [DATA_WIDTH-1:0] c_q;

    // Only the low bits of b_i select the shift distance; upper bits are ignored.
    assign shamt       = b_i[SHIFT_W-1:0];
    assign sum         = a_i + b_i;
    assign diff        = a_i - b_i;
    assign sra_res     = DATA_WIDTH'($signed(a_i) >>> shamt);
    assign lt_signed   = $signed(a_i) < $signed(b_i);
    assign lt_unsigned = a_i < b_i;

    always_comb begin
        c_d = '0;
        unique case (alu_op_i)
            OP_ADD:   c_d = sum;
            OP_SUB:   c_d = diff;
            OP_AND:   c_d = a_i & b_i;
            OP_OR:    c_d = a_i | b_i;
            OP_XOR:   c_d = a_i ^ b_i;
            OP_SLT:   c_d = DATA_WIDTH'(lt_signed);
            OP_SLTU:  c_d = DATA_WIDTH'(lt_unsigned);
            OP_SLL:   c_d = a_i << shamt;
            OP_SRL:   c_d = a_i >> shamt;
            OP_SRA:   c_d = sra_res;
            OP_PASSB: c_d = b_i;
            default:  c_d = '0;
        endcase
    end

    assign c_o    = c_d;
    assign zero_o = (c_d == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            c_q <= '0;
        end else begin
            c_q <= c_d;
        end
    end

    assign c_q_o = c_q;

`ifdef ALU_FLAGS_EN
    logic [DATA_WIDTH:0] add_ext;
    logic [DATA_WIDTH:0] sub_ext;
    logic                flag_c;
    logic                flag_v;
    logic [3:0]          flags_d;
    logic [3:0]          flags_q;

    // SUB carry is computed as a + ~b + 1, so the carry-out is NOT borrow.
    assign add_ext = {1'b0, a_i} + {1'b0, b_i};
    assign sub_ext = {1'b0, a_i} + {1'b0, ~b_i} + (DATA_WIDTH + 1)'(1);

    always_comb begin
        flag_c = 1'b0;
        flag_v = 1'b0;
        if (alu_op_i == OP_ADD) begin
            flag_c = add_ext[DATA_WIDTH];
            flag_v = (a_i[DATA_WIDTH-1] == b_i[DATA_WIDTH-1]) &&
                     (sum[DATA_WIDTH-1] != a_i[DATA_WIDTH-1]);
        end else if (alu_op_i == OP_SUB) begin
            flag_c = sub_ext[DATA_WIDTH];
            flag_v = (a_i[DATA_WIDTH-1] != b_i[DATA_WIDTH-1]) &&
                     (diff[DATA_WIDTH-1] != a_i[DATA_WIDTH-1]);
        end
    end

    assign flags_d = {c_d[DATA_WIDTH-1], zero_o, flag_c, flag_v};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags_o = flags_q;
`endif

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: self-checking bench for alu_unit.
// Table-driven vectors check c_o/zero_o combinationally; expected c_o values
// are queued when driven and popped against c_q_o after the capturing edge.
// Hand-written sequences cover reset behaviour and (with ALU_FLAGS_EN) flags.

module tb_alu_unit;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [5:0]  alu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        zero;
    logic [31:0] c_q;
`ifdef ALU_FLAGS_EN
    logic [3:0]  flags;
`endif

    int          total;
    int          bad;
    logic [31:0] sb[$];
    vec_t        vecs[$];

    alu_unit #(
        .DATA_WIDTH(32)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .alu_op_i(alu_op),
        .a_i     (a),
        .b_i     (b),
        .c_o     (c),
        .zero_o  (zero),
        .c_q_o   (c_q)
`ifdef ALU_FLAGS_EN
        ,
        .flags_o (flags)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string name);
        logic [31:0] exp;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: scoreboard empty, got 0x%08h", name, c_q);
        end else begin
            exp = sb.pop_front();
            check(name, c_q, exp);
        end
    endtask

    // Drive between edges, check the combinational result, then the captured copy.
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        alu_op = v.op;
        a      = v.a;
        b      = v.b;
        #1;
        check($sformatf("c_o[%0d]", idx), c, v.c);
        check($sformatf("zero_o[%0d]", idx), {31'd0, zero}, {31'd0, (v.c == 32'd0)});
        sb.push_back(v.c);
        @(posedge clk);
        #1;
        pop_check($sformatf("c_q_o[%0d]", idx));
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        alu_op = 6'd0;
        a      = 32'd0;
        b      = 32'd0;

        vecs.push_back('{6'd0,  32'h0000_0001, 32'h0000_0001, 32'h0000_0002});
        vecs.push_back('{6'd1,  32'h0000_0001, 32'h0000_0001, 32'h0000_0000});
        vecs.push_back('{6'd2,  32'h0000_0101, 32'h0001_0001, 32'h0000_0001});
        vecs.push_back('{6'd3,  32'h0000_0101, 32'h0001_0001, 32'h0001_0101});
        vecs.push_back('{6'd4,  32'h0000_0101, 32'h0001_0001, 32'h0001_0100});
        vecs.push_back('{6'd5,  32'hFFFF_FFF0, 32'h0000_0010, 32'h0000_0001});
        vecs.push_back('{6'd5,  32'h0000_0010, 32'hFFFF_FFF0, 32'h0000_0000});
        vecs.push_back('{6'd6,  32'h0000_0010, 32'hFFFF_FFF0, 32'h0000_0001});
        vecs.push_back('{6'd6,  32'hFFFF_FFF0, 32'h0000_0010, 32'h0000_0000});
        vecs.push_back('{6'd7,  32'h0000_0001, 32'h0000_0004, 32'h0000_0010});
        vecs.push_back('{6'd8,  32'h0000_0100, 32'h0000_0001, 32'h0000_0080});
        vecs.push_back('{6'd9,  32'hFFFF_F000, 32'h0000_0004, 32'hFFFF_FF00});
        vecs.push_back('{6'd9,  32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF});
        vecs.push_back('{6'd9,  32'h8000_0000, 32'h0000_0000, 32'h8000_0000});
        vecs.push_back('{6'd7,  32'h0000_0001, 32'h0000_0024, 32'h0000_0010});
        vecs.push_back('{6'd8,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001});
        vecs.push_back('{6'd10, 32'hDEAD_BEEF, 32'h1234_5000, 32'h1234_5000});
        vecs.push_back('{6'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000});
        vecs.push_back('{6'd1,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF});
        vecs.push_back('{6'd63, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000});
        vecs.push_back('{6'd11, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000});
        vecs.push_back('{6'd0,  32'h0000_0003, 32'h0000_0004, 32'h0000_0007});

        // Reset state, then release away from an edge (edges at 5, 15, ...).
        #1;
        check("c_q_o reset", c_q, 32'd0);
`ifdef ALU_FLAGS_EN
        check("flags_o reset", {28'd0, flags}, 32'd0);
`endif
        #11;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Mid-run asynchronous reset: pending capture is discarded.
        @(negedge clk);
        alu_op = 6'd0;
        a      = 32'd5;
        b      = 32'd6;
        sb.push_back(32'd11);
        #2;
        rst_n = 1'b0;
        #1;
        check("c_q_o async reset", c_q, 32'd0);
`ifdef ALU_FLAGS_EN
        check("flags_o async reset", {28'd0, flags}, 32'd0);
`endif
        sb.delete();
        @(posedge clk);
        #1;
        check("c_q_o held in reset", c_q, 32'd0);
        check("c_o during reset", c, 32'd11);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        sb.push_back(32'd11);
        @(posedge clk);
        #1;
        pop_check("c_q_o first capture after reset");

`ifdef ALU_FLAGS_EN
        // Signed overflow: 0x7FFFFFFF + 1 -> N=1 Z=0 C=0 V=1.
        @(negedge clk);
        alu_op = 6'd0;
        a      = 32'h7FFF_FFFF;
        b      = 32'h0000_0001;
        @(posedge clk);
        #1;
        check("flags ADD overflow", {28'd0, flags}, 32'h9);
        // 1 - 1: Z=1, no borrow so C=1.
        @(negedge clk);
        alu_op = 6'd1;
        a      = 32'd1;
        b      = 32'd1;
        @(posedge clk);
        #1;
        check("flags SUB equal", {28'd0, flags}, 32'h6);
        // 0xFFFFFFFF + 1: carry out, zero result.
        @(negedge clk);
        alu_op = 6'd0;
        a      = 32'hFFFF_FFFF;
        b      = 32'd1;
        @(posedge clk);
        #1;
        check("flags ADD carry", {28'd0, flags}, 32'h6);
        // Logic op: C and V forced low, N from result.
        @(negedge clk);
        alu_op = 6'd3;
        a      = 32'h8000_0000;
        b      = 32'd0;
        @(posedge clk);
        #1;
        check("flags OR", {28'd0, flags}, 32'h8);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
